// File: rtl/inst_mem.sv
// Instruction memory for the RV32IMV fetch path.
// Reads are combinational with zero latency. A clocked write port loads or
// patches the program image. Fetches that are out of range or misaligned are
// flagged and return a NOP. Writes that are out of range or misaligned are
// dropped, and they set a sticky error flag that stays set until reset.
// Reset clears only that flag and forces the fetched word to NOP. It never
// clears the storage.
module inst_mem #(
    parameter int    DEPTH     = 256,
    parameter int    ADDR_MODE = 0,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] InstAddress,
    output logic [31:0] Inst,
    output logic        AddrErr,
    input  logic        we,
    input  logic [31:0] WriteAddress,
    input  logic [31:0] WriteData,
    output logic        WrErr
);

    localparam int          AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Storage powers up as all-NOP.
    logic [31:0] r_mem [DEPTH] = '{default: NOP};
    logic        r_wr_err;

    logic [31:0] w_rd_idx;
    logic [31:0] w_wr_idx;
    logic        w_rd_mis;
    logic        w_wr_mis;
    logic        w_rd_err;
    logic        w_wr_err;

    generate
        if (ADDR_MODE == 1) begin : g_byte_addr
            // Byte addressing: the word index is the address divided by 4,
            // and any nonzero low bit makes the access misaligned.
            assign w_rd_idx = {2'b00, InstAddress[31:2]};
            assign w_wr_idx = {2'b00, WriteAddress[31:2]};
            assign w_rd_mis = |InstAddress[1:0];
            assign w_wr_mis = |WriteAddress[1:0];
        end else begin : g_word_addr
            assign w_rd_idx = InstAddress;
            assign w_wr_idx = WriteAddress;
            assign w_rd_mis = 1'b0;
            assign w_wr_mis = 1'b0;
        end
    endgenerate

    // Compare the full 32-bit index, so high address bits never alias
    // back into the array.
    assign w_rd_err = (w_rd_idx >= 32'(DEPTH)) || w_rd_mis;
    assign w_wr_err = (w_wr_idx >= 32'(DEPTH)) || w_wr_mis;

    assign AddrErr = w_rd_err;
    assign WrErr   = r_wr_err;

    // Combinational fetch. The error check gates the array access, so an
    // out-of-range index is never used.
    always_comb begin
        Inst = NOP;
        if (!rst && !w_rd_err) begin
            Inst = r_mem[w_rd_idx[AW-1:0]];
        end
    end

    // Store legal writes. A write at an edge where reset is high is dropped.
    always_ff @(posedge clk) begin
        if (we && !rst && !w_wr_err) begin
            r_mem[w_wr_idx[AW-1:0]] <= WriteData;
        end
    end

    // Sticky illegal-write flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_err <= 1'b0;
        end else if (we && w_wr_err) begin
            r_wr_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_inst_mem.sv
// Testbench for inst_mem.
// Two instances, each with 16 words: one word-addressed, one byte-addressed.
// A behavioural model of the memory contents and of the sticky write-error
// flags is kept here in the bench.
module tb_inst_mem;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] ia0 = '0, wa0 = '0, wd0 = '0, inst0;
    logic        we0 = 1'b0, aerr0, wrerr0;
    logic [31:0] ia1 = '0, wa1 = '0, wd1 = '0, inst1;
    logic        we1 = 1'b0, aerr1, wrerr1;

    logic [31:0] mem0 [16];
    logic [31:0] mem1 [16];
    logic        m_werr0, m_werr1;

    int total = 0;
    int bad   = 0;

    always #2 clk = ~clk;

    inst_mem #(.DEPTH(16), .ADDR_MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .InstAddress(ia0), .Inst(inst0), .AddrErr(aerr0),
        .we(we0), .WriteAddress(wa0), .WriteData(wd0), .WrErr(wrerr0)
    );

    inst_mem #(.DEPTH(16), .ADDR_MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .InstAddress(ia1), .Inst(inst1), .AddrErr(aerr1),
        .we(we1), .WriteAddress(wa1), .WriteData(wd1), .WrErr(wrerr1)
    );

    // Reference model: the address is legal when its word index is below 16.
    // In byte mode it must also be aligned to 4.
    function automatic bit legal(input int m, input logic [31:0] a);
        logic [31:0] idx;
        idx = (m == 1) ? (a / 4) : a;
        return (idx < 16) && !((m == 1) && (a % 4 != 0));
    endfunction

    function automatic logic [31:0] exp_inst(input int m, input logic [31:0] a);
        logic [31:0] idx;
        idx = (m == 1) ? (a / 4) : a;
        if (rst || !legal(m, a)) return NOP;
        return (m == 1) ? mem1[idx[3:0]] : mem0[idx[3:0]];
    endfunction

    // Drive one write across a rising edge and update the model the same way.
    task automatic do_write(input int m, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        if (m == 0) begin we0 = 1'b1; wa0 = a; wd0 = d; end
        else        begin we1 = 1'b1; wa1 = a; wd1 = d; end
        @(posedge clk);
        if (!rst) begin
            if (legal(m, a)) begin
                if (m == 0) mem0[a[3:0]] = d;
                else        mem1[a[5:2]] = d;
            end else begin
                if (m == 0) m_werr0 = 1'b1;
                else        m_werr1 = 1'b1;
            end
        end
        #1;
        we0 = 1'b0;
        we1 = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++; if (inst0 !== NOP) begin bad++; $display("FAIL reset_inst0 got=%h exp=%h", inst0, NOP); end
        total++; if (inst1 !== NOP) begin bad++; $display("FAIL reset_inst1 got=%h exp=%h", inst1, NOP); end
        total++; if (wrerr0 !== 1'b0) begin bad++; $display("FAIL reset_wrerr0 got=%b exp=0", wrerr0); end
        total++; if (aerr0 !== 1'b0) begin bad++; $display("FAIL reset_aerr0 got=%b exp=0", aerr0); end
        ia0 = 32'd16;
        #1;
        total++; if (aerr0 !== 1'b1) begin bad++; $display("FAIL reset_aerr0_oor got=%b exp=1", aerr0); end
        ia0 = 32'd0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_default_fill();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ia0 = i;
            #1;
            total++;
            if (inst0 !== NOP || aerr0 !== 1'b0) begin
                bad++;
                $display("FAIL default_fill addr=%0d got=%h/%b exp=%h/0", i, inst0, aerr0, NOP);
            end
        end
    endtask

    task automatic test_load_read();
        do_write(0, 32'd0, 32'h0050_0093);
        do_write(0, 32'd1, 32'h0010_8113);
        ia0 = 32'd0;
        #1;
        total++; if (inst0 !== 32'h0050_0093) begin bad++; $display("FAIL load_w0 got=%h exp=00500093", inst0); end
        ia0 = 32'd1;
        #1;
        total++; if (inst0 !== 32'h0010_8113) begin bad++; $display("FAIL load_w1 got=%h exp=00108113", inst0); end
        // Old data must show before the edge and new data right after it.
        @(negedge clk);
        ia0 = 32'd2; we0 = 1'b1; wa0 = 32'd2; wd0 = 32'hCAFE_0001;
        #1;
        total++; if (inst0 !== NOP) begin bad++; $display("FAIL pre_edge_old got=%h exp=%h", inst0, NOP); end
        @(posedge clk);
        mem0[2] = 32'hCAFE_0001;
        #1;
        we0 = 1'b0;
        total++; if (inst0 !== 32'hCAFE_0001) begin bad++; $display("FAIL post_edge_new got=%h exp=cafe0001", inst0); end
    endtask

    task automatic test_out_of_range();
        ia0 = 32'd16;
        #1;
        total++; if (inst0 !== NOP || aerr0 !== 1'b1) begin bad++; $display("FAIL oor16 got=%h/%b exp=%h/1", inst0, aerr0, NOP); end
        ia0 = 32'h8000_0000;
        #1;
        total++; if (inst0 !== NOP || aerr0 !== 1'b1) begin bad++; $display("FAIL oor_high got=%h/%b exp=%h/1", inst0, aerr0, NOP); end
        do_write(0, 32'd16, 32'hBAD0_BAD0);
        total++; if (wrerr0 !== 1'b1) begin bad++; $display("FAIL wrerr_set got=%b exp=1", wrerr0); end
        ia0 = 32'd0;
        #1;
        total++; if (inst0 !== 32'h0050_0093) begin bad++; $display("FAIL oor_w0_kept got=%h exp=00500093", inst0); end
        do_write(0, 32'd3, 32'h1111_2222);
        total++; if (wrerr0 !== 1'b1) begin bad++; $display("FAIL wrerr_sticky got=%b exp=1", wrerr0); end
    endtask

    task automatic test_byte_mode();
        do_write(1, 32'd4, 32'hDEAD_BEEF);
        ia1 = 32'd4;
        #1;
        total++; if (inst1 !== 32'hDEAD_BEEF || aerr1 !== 1'b0) begin bad++; $display("FAIL byte_a4 got=%h/%b exp=deadbeef/0", inst1, aerr1); end
        for (int off = 5; off < 8; off++) begin
            ia1 = off;
            #1;
            total++; if (inst1 !== NOP || aerr1 !== 1'b1) begin bad++; $display("FAIL byte_mis a=%0d got=%h/%b exp=%h/1", off, inst1, aerr1, NOP); end
        end
        ia1 = 32'd64;
        #1;
        total++; if (aerr1 !== 1'b1) begin bad++; $display("FAIL byte_oor64 got=%b exp=1", aerr1); end
        ia1 = 32'd60;
        #1;
        total++; if (aerr1 !== 1'b0 || inst1 !== NOP) begin bad++; $display("FAIL byte_last got=%h/%b exp=%h/0", inst1, aerr1, NOP); end
        do_write(1, 32'd9, 32'h7777_7777);
        total++; if (wrerr1 !== 1'b1) begin bad++; $display("FAIL byte_mis_wr got=%b exp=1", wrerr1); end
        ia1 = 32'd8;
        #1;
        total++; if (inst1 !== NOP) begin bad++; $display("FAIL byte_mis_kept got=%h exp=%h", inst1, NOP); end
        ia1 = 32'd4;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #1;
        rst = 1'b1; m_werr0 = 1'b0; m_werr1 = 1'b0;
        #0.5;
        total++; if (inst1 !== NOP) begin bad++; $display("FAIL async_inst got=%h exp=%h", inst1, NOP); end
        total++; if (wrerr1 !== 1'b0 || wrerr0 !== 1'b0) begin bad++; $display("FAIL async_wrerr got=%b%b exp=00", wrerr1, wrerr0); end
        rst = 1'b0;
        #0.5;
        total++; if (inst1 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL async_restore got=%h exp=deadbeef", inst1); end
    endtask

    task automatic test_write_during_reset();
        @(negedge clk);
        rst = 1'b1;
        do_write(1, 32'd4, 32'h1234_5678);
        do_write(1, 32'd99, 32'h1234_5678);
        total++; if (wrerr1 !== 1'b0) begin bad++; $display("FAIL rst_wr_wrerr got=%b exp=0", wrerr1); end
        @(negedge clk);
        rst = 1'b0;
        ia1 = 32'd4;
        #1;
        total++; if (inst1 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rst_wr_dropped got=%h exp=deadbeef", inst1); end
        total++; if (wrerr1 !== 1'b0) begin bad++; $display("FAIL rst_wr_after got=%b exp=0", wrerr1); end
    endtask

    task automatic test_random();
        int m, op, r;
        logic [31:0] a, d, got;
        logic gae, gwe;
        for (int n = 0; n < 400; n++) begin
            m  = $urandom_range(0, 1);
            op = $urandom_range(0, 2);
            r  = $urandom_range(0, 9);
            if (r == 0) a = $urandom;
            else        a = (m == 1) ? $urandom_range(0, 71) : $urandom_range(0, 19);
            if (op == 0) begin
                d = $urandom;
                do_write(m, a, d);
                gwe = (m == 1) ? wrerr1 : wrerr0;
                total++;
                if (gwe !== ((m == 1) ? m_werr1 : m_werr0)) begin
                    bad++; $display("FAIL rand_wrerr m=%0d a=%h got=%b exp=%b", m, a, gwe, (m == 1) ? m_werr1 : m_werr0);
                end
            end else begin
                if (m == 1) ia1 = a; else ia0 = a;
                #1;
                got = (m == 1) ? inst1 : inst0;
                gae = (m == 1) ? aerr1 : aerr0;
                total++;
                if (got !== exp_inst(m, a) || gae !== !legal(m, a)) begin
                    bad++; $display("FAIL rand_read m=%0d a=%h got=%h/%b exp=%h/%b", m, a, got, gae, exp_inst(m, a), !legal(m, a));
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin mem0[i] = NOP; mem1[i] = NOP; end
        m_werr0 = 1'b0;
        m_werr1 = 1'b0;
        test_reset();
        test_default_fill();
        test_load_read();
        test_out_of_range();
        test_byte_mode();
        test_async_reset();
        test_write_during_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
